// File: rtl/color_fader.sv
// color_fader: ramps a 24-bit RGB colour toward a requested target one LSB
// per channel per step, pacing the ramp with the PWM mixer's end-of-period
// tick. When the target is reached, the colour is held for a fixed number of
// periods. Then done_o pulses and the block accepts a new target.
module color_fader #(
   parameter int unsigned STEP_PERIODS = 4,   // PWM periods per ramp step, 1..255
   parameter int unsigned HOLD_PERIODS = 64   // PWM periods held at target, 1..65535
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tick_i,
   input  logic [23:0] target_i,
   input  logic        target_valid_i,
   output logic        target_ready_o,
   input  logic        abort_i,
   output logic [23:0] color_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FADE = 2'd1,
      HOLD = 2'd2
   } state_t;

   // The counters are compared against "last" values, so the comparison
   // stays inside the 8- and 16-bit counter widths.
   localparam logic [7:0]  STEP_LAST = 8'(STEP_PERIODS - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_PERIODS - 1);

   state_t      state_q, state_d;
   logic [23:0] color_q, color_d;
   logic [23:0] target_q, target_d;
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic        done_q, done_d;
   logic [23:0] color_stepped;

   // Moves one 8-bit channel one LSB toward its target. It compares before
   // changing the value, so the channel cannot overshoot or wrap.
   function automatic logic [7:0] step_channel(input logic [7:0] cur,
                                               input logic [7:0] tgt);
      logic [7:0] res;
      res = cur;
      if (cur < tgt) begin
         res = cur + 8'd1;
      end else if (cur > tgt) begin
         res = cur - 8'd1;
      end
      return res;
   endfunction

   // Candidate colour for the next ramp step. Each channel is stepped independently.
   always_comb begin
      color_stepped = {step_channel(color_q[23:16], target_q[23:16]),
                       step_channel(color_q[15:8],  target_q[15:8]),
                       step_channel(color_q[7:0],   target_q[7:0])};
   end

   // Next-state logic: handshake, tick-paced ramp, hold countdown and abort.
   always_comb begin
      // NOTE: each variable driven here gets a default before any branch, so
      // no path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      color_d    = color_q;
      target_d   = target_q;
      step_cnt_d = step_cnt_q;
      hold_cnt_d = hold_cnt_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A tick in the acceptance cycle is ignored because the counters restart here.
            if (target_valid_i) begin
               target_d   = target_i;
               step_cnt_d = '0;
               hold_cnt_d = '0;
               state_d    = (target_i == color_q) ? HOLD : FADE;
            end
         end

         FADE: begin
            if (abort_i) begin
               // Abort takes priority over a coincident step tick, so the colour stays frozen.
               step_cnt_d = '0;
               hold_cnt_d = '0;
               state_d    = IDLE;
            end else if (tick_i) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  color_d    = color_stepped;
                  if (color_stepped == target_q) begin
                     hold_cnt_d = '0;
                     state_d    = HOLD;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 8'd1;
               end
            end
         end

         HOLD: begin
            if (abort_i) begin
               // Abort on the final hold tick also wins, so done_o stays low.
               step_cnt_d = '0;
               hold_cnt_d = '0;
               state_d    = IDLE;
            end else if (tick_i) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 16'd1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset has priority over any handshake.
   always_ff @(posedge clk_i) begin
      // NOTE: registers use non-blocking assignments. Every flop then samples
      // pre-edge values, and the result does not depend on process order.
      if (rst_i) begin
         state_q    <= IDLE;
         color_q    <= '0;
         target_q   <= '0;
         step_cnt_q <= '0;
         hold_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         color_q    <= color_d;
         target_q   <= target_d;
         step_cnt_q <= step_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         done_q     <= done_d;
      end
   end

   // Status outputs are decoded from the registered state.
   assign target_ready_o = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign color_o        = color_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_color_fader.sv
// tb_color_fader: runs two color_fader instances with different pacing
// parameters (u_a: step 1, hold 2; u_b: step 2, hold 5). The stimulus is
// directed scenarios followed by random traffic. A reference model tracks
// each fade as "ticks counted since acceptance".
module tb_color_fader;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick   [2];
   logic        valid  [2];
   logic        abort  [2];
   logic [23:0] tgt    [2];
   logic [23:0] color  [2];
   logic        ready  [2];
   logic        busy   [2];
   logic        done   [2];

   int total = 0;
   int bad   = 0;

   // Reference model state, one entry per instance.
   int          step_m  [2];
   int          hold_m  [2];
   logic        m_busy  [2];
   logic        m_done  [2];
   logic [23:0] m_color [2];
   logic [23:0] m_start [2];
   logic [23:0] m_tgt   [2];
   int          m_n     [2];
   int          m_end   [2];

   logic [23:0] seq [4];

   always #5 clk = ~clk;

   color_fader #(.STEP_PERIODS(1), .HOLD_PERIODS(2)) u_a (
      .clk_i(clk), .rst_i(rst), .tick_i(tick[0]), .target_i(tgt[0]),
      .target_valid_i(valid[0]), .target_ready_o(ready[0]), .abort_i(abort[0]),
      .color_o(color[0]), .busy_o(busy[0]), .done_o(done[0]));

   color_fader #(.STEP_PERIODS(2), .HOLD_PERIODS(5)) u_b (
      .clk_i(clk), .rst_i(rst), .tick_i(tick[1]), .target_i(tgt[1]),
      .target_valid_i(valid[1]), .target_ready_o(ready[1]), .abort_i(abort[1]),
      .color_o(color[1]), .busy_o(busy[1]), .done_o(done[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Colour reached after k steps: each channel moves min(k, |delta|) toward the target.
   function automatic logic [23:0] fade_at(input logic [23:0] s, input logic [23:0] t, input int k);
      logic [23:0] r;
      for (int c = 0; c < 3; c++) begin
         int sv = int'(s[c*8 +: 8]);
         int tv = int'(t[c*8 +: 8]);
         int d  = (tv > sv) ? tv - sv : sv - tv;
         int mv = (d < k) ? d : k;
         r[c*8 +: 8] = 8'((tv > sv) ? sv + mv : sv - mv);
      end
      return r;
   endfunction

   function automatic int max_delta(input logic [23:0] s, input logic [23:0] t);
      int m = 0;
      for (int c = 0; c < 3; c++) begin
         int sv = int'(s[c*8 +: 8]);
         int tv = int'(t[c*8 +: 8]);
         int d  = (tv > sv) ? tv - sv : sv - tv;
         if (d > m) m = d;
      end
      return m;
   endfunction

   // One clock: advance the model with the inputs sampled at this edge, then compare at the falling edge.
   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (rst) begin
            m_busy[i]  = 1'b0;
            m_color[i] = '0;
         end else if (!m_busy[i]) begin
            if (valid[i]) begin
               m_start[i] = m_color[i];
               m_tgt[i]   = tgt[i];
               m_n[i]     = 0;
               m_busy[i]  = 1'b1;
               m_end[i]   = max_delta(m_color[i], tgt[i]) * step_m[i] + hold_m[i];
            end
         end else if (abort[i]) begin
            m_busy[i] = 1'b0;
         end else if (tick[i]) begin
            m_n[i]++;
            m_color[i] = fade_at(m_start[i], m_tgt[i], m_n[i] / step_m[i]);
            if (m_n[i] == m_end[i]) begin
               m_busy[i] = 1'b0;
               m_done[i] = 1'b1;
            end
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d color", i), 32'(color[i]), 32'(m_color[i]));
         check($sformatf("u%0d busy/ready/done", i), {29'd0, busy[i], ready[i], done[i]},
               {29'd0, m_busy[i], ~m_busy[i], m_done[i]});
      end
   endtask

   initial begin
      step_m[0] = 1; hold_m[0] = 2;
      step_m[1] = 2; hold_m[1] = 5;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick[i] = 1'b0; valid[i] = 1'b0; abort[i] = 1'b0; tgt[i] = '0;
         m_busy[i] = 1'b0; m_done[i] = 1'b0; m_color[i] = '0;
         m_start[i] = '0; m_tgt[i] = '0; m_n[i] = 0; m_end[i] = 0;
      end
      cyc(); cyc();
      check("reset color", 32'(color[0]), 32'h0);
      check("reset ready", 32'(ready[0]), 32'd1);
      rst = 1'b0;
      cyc();

      // Basic fade on u_a: 000000 -> 030001, tick every 256 cycles.
      seq[0] = 24'h010001; seq[1] = 24'h020001; seq[2] = 24'h030001; seq[3] = 24'h030001;
      valid[0] = 1'b1; tgt[0] = 24'h030001;
      cyc();
      valid[0] = 1'b0;
      check("accept busy", 32'(busy[0]), 32'd1);
      check("accept ready", 32'(ready[0]), 32'd0);
      for (int t = 1; t <= 5; t++) begin
         repeat (255) cyc();
         tick[0] = 1'b1;
         cyc();
         tick[0] = 1'b0;
         check($sformatf("basic color t%0d", t), 32'(color[0]), 32'(seq[(t > 3) ? 3 : t - 1]));
         check($sformatf("basic done t%0d", t), 32'(done[0]), (t == 5) ? 32'd1 : 32'd0);
      end
      cyc();
      check("done one cycle", 32'(done[0]), 32'd0);

      // Equal target: straight to HOLD, done after exactly HOLD_PERIODS ticks.
      valid[0] = 1'b1; tgt[0] = 24'h030001;
      cyc();
      valid[0] = 1'b0;
      check("equal busy", 32'(busy[0]), 32'd1);
      for (int h = 1; h <= 2; h++) begin
         tick[0] = 1'b1;
         cyc();
         check($sformatf("equal done h%0d", h), 32'(done[0]), (h == 2) ? 32'd1 : 32'd0);
         check("equal color", 32'(color[0]), 32'h030001);
      end
      tick[0] = 1'b0;
      cyc();

      // Back-pressure: a valid held during HOLD is taken in the done cycle.
      valid[0] = 1'b1; tgt[0] = 24'h040001;
      cyc();
      valid[0] = 1'b0; tick[0] = 1'b1;
      cyc();
      tick[0] = 1'b0;
      check("bp in hold", 32'(color[0]), 32'h040001);
      valid[0] = 1'b1; tgt[0] = 24'h000000;
      cyc();
      check("bp not accepted", 32'(busy[0]), 32'd1);
      tick[0] = 1'b1;
      cyc(); cyc();
      tick[0] = 1'b0;
      check("bp done", 32'(done[0]), 32'd1);
      check("bp ready with done", 32'(ready[0]), 32'd1);
      cyc();
      valid[0] = 1'b0;
      check("bp busy again", 32'(busy[0]), 32'd1);
      tick[0] = 1'b1;
      repeat (6) cyc();
      tick[0] = 1'b0;
      check("bp second done", 32'(done[0]), 32'd1);

      // Mixed directions on u_b: first ramp up to FF0080.
      valid[1] = 1'b1; tgt[1] = 24'hFF0080;
      cyc();
      valid[1] = 1'b0; tick[1] = 1'b1;
      repeat (255 * 2 + 5) cyc();
      tick[1] = 1'b0;
      check("ramp up color", 32'(color[1]), 32'hFF0080);
      check("ramp up idle", 32'(busy[1]), 32'd0);
      seq[0] = 24'hFF0080; seq[1] = 24'hFE0180; seq[2] = 24'hFE0180; seq[3] = 24'hFD0280;
      valid[1] = 1'b1; tgt[1] = 24'hFD0280;
      cyc();
      valid[1] = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         tick[1] = 1'b1;
         cyc();
         check($sformatf("mixed color t%0d", t), 32'(color[1]), 32'(seq[t - 1]));
      end
      tick[1] = 1'b0;
      check("mixed in hold", 32'(busy[1]), 32'd1);

      // Abort in HOLD, then abort coincident with a step tick.
      abort[1] = 1'b1;
      cyc();
      abort[1] = 1'b0;
      check("abort hold idle", 32'(busy[1]), 32'd0);
      check("abort hold no done", 32'(done[1]), 32'd0);
      valid[1] = 1'b1; tgt[1] = 24'hFD0580;
      cyc();
      valid[1] = 1'b0; tick[1] = 1'b1;
      repeat (3) cyc();
      abort[1] = 1'b1;
      cyc();
      abort[1] = 1'b0; tick[1] = 1'b0;
      check("abort step color", 32'(color[1]), 32'hFD0380);
      check("abort step idle", 32'(busy[1]), 32'd0);
      check("abort step no done", 32'(done[1]), 32'd0);
      valid[1] = 1'b1; tgt[1] = 24'hFD0480;
      cyc();
      valid[1] = 1'b0; tick[1] = 1'b1;
      cyc(); cyc();
      check("resume color", 32'(color[1]), 32'hFD0480);

      // Reset mid-fade, with handshakes offered during reset.
      tgt[1] = 24'h000000;
      repeat (5) cyc();
      valid[1] = 1'b1;
      cyc();
      valid[1] = 1'b0;
      repeat (4) cyc();
      check("pre-reset busy", 32'(busy[1]), 32'd1);
      rst = 1'b1; valid[0] = 1'b1; valid[1] = 1'b1; tgt[0] = 24'h112233; tgt[1] = 24'h445566;
      cyc();
      check("rst color", 32'(color[1]), 32'h0);
      check("rst busy", 32'(busy[1]), 32'd0);
      check("rst ready", 32'(ready[1]), 32'd1);
      check("rst done", 32'(done[1]), 32'd0);
      cyc();
      rst = 1'b0; valid[0] = 1'b0; valid[1] = 1'b0; tick[1] = 1'b0;
      cyc();
      check("rst no accept u0", 32'(busy[0]), 32'd0);
      check("rst no accept u1", 32'(busy[1]), 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 30000; n++) begin
         rst = ($urandom_range(0, 2999) == 0);
         for (int i = 0; i < 2; i++) begin
            tick[i]  = ($urandom_range(0, 2) == 0);
            abort[i] = ($urandom_range(0, 299) == 0);
            valid[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) tgt[i] = 24'($urandom);
            else tgt[i] = m_color[i] ^ (24'($urandom) & 24'h070307);
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/color_fader.md
# color_fader

Sequencer that drives the 24-bit `color_i` input of the RGB PWM mixer. It accepts a target colour over a valid/ready handshake and ramps each 8-bit channel toward it one LSB at a time. The ramp is paced by the mixer's end-of-PWM-period pulse, so the colour only changes on period boundaries. After reaching the target it holds for a programmable number of periods, pulses `done_o`, and becomes ready again.

## Interface
- `STEP_PERIODS`, default 4: PWM periods per ramp step; legal range 1..255.
- `HOLD_PERIODS`, default 64: PWM periods held at target before `done_o`; legal range 1..65535.

- `clk_i` in 1: single clock, shared with the mixer.
- `rst_i` in 1: reset, synchronous, active-high.
- `tick_i` in 1: end-of-PWM-period pulse; connects to the mixer's `timeout_o`.
- `target_i` in 24: target colour {R[23:16], G[15:8], B[7:0]}.
- `target_valid_i` in 1: `target_i` is valid.
- `target_ready_o` out 1: block can accept a target.
- `abort_i` in 1: cancel the fade/hold in progress.
- `color_o` out 24: current colour; connects to the mixer's `color_i`.
- `busy_o` out 1: high in FADE or HOLD.
- `done_o` out 1: one-cycle pulse when a hold completes.

## Operation
- States: IDLE, FADE, HOLD.
- `target_ready_o` = (state == IDLE). `busy_o` = (state != IDLE). Both are decoded from the registered state.
- **Reset** (`rst_i` high at a clock edge):
  - state = IDLE, `color_o` = 24'h000000, `done_o` = 0.
  - Step and hold counters cleared, latched target = 0.
  - A handshake sampled while `rst_i` is high is ignored.
  - Reset mid-fade or mid-hold aborts immediately; no `done_o`.
- **IDLE:** on `target_valid_i && target_ready_o`:
  - Latch `target_i` and clear both counters.
  - If latched target == `color_o`, go to HOLD; otherwise go to FADE.
  - `abort_i` has no effect in IDLE.
- **FADE:**
  - Step counter counts `tick_i` pulses.
  - On the tick where the counter reaches `STEP_PERIODS`, the counter clears and each channel independently moves one LSB toward its target: +1 if below, -1 if above, unchanged if equal.
  - No overshoot and no wrap (255 never steps to 0, 0 never steps to 255).
  - If the stepped value equals the target, go to HOLD and clear the hold counter at the same edge.
- **HOLD:**
  - Hold counter counts `tick_i` pulses; `color_o` is frozen.
  - On the `HOLD_PERIODS`-th tick, go to IDLE and set `done_o` = 1 for exactly one cycle.
- **abort_i in FADE or HOLD:** go to IDLE at the next edge. `color_o` keeps its current value, no `done_o`, counters cleared.
- **Simultaneous events:**
  - `abort_i` with a step tick: abort wins and `color_o` is not updated.
  - `abort_i` with the final hold tick: abort wins, no `done_o`.
- **Width rules:**
  - Step counter is 8 bits; hold counter is 16 bits.
  - Channel arithmetic is an 8-bit compare-then-increment/decrement; no carry between channels.

## Timing
- Acceptance at edge k: at k+1, `busy_o` = 1 and `target_ready_o` = 0.
- A `tick_i` high during the acceptance cycle is not counted.
- `color_o` changes only at an edge where `tick_i` = 1 is sampled. Because `timeout_o` is high while the mixer count is 255, every new value applies from count 0 of the next PWM period, so no period is glitched.
- Fade length is max over channels of |target − start| × `STEP_PERIODS` ticks.
- `done_o` is asserted the cycle after the final hold tick is sampled. `target_ready_o` rises in the same cycle, so a new target can be accepted at that same edge.
- Back-to-back targets: a valid held high during FADE/HOLD is accepted at the first edge where the block is in IDLE.

## Test plan
- **Reset:** assert `rst_i` mid-FADE.
  - Next cycle: `color_o` = 0, `busy_o` = 0, `target_ready_o` = 1, `done_o` = 0.
  - Handshakes sampled during reset are not accepted.
- **Basic fade:** `STEP_PERIODS` = 1, `HOLD_PERIODS` = 2, target 24'h030001 from 0, tick every 256 cycles.
  - `color_o` sequence: 010001, 020001, 030001 on ticks 1–3.
  - Ticks 4–5 hold; `done_o` pulses once, one cycle after tick 5.
- **Mixed directions:** from 24'hFF00_80, target 24'hFD02_80, `STEP_PERIODS` = 2.
  - R decrements and G increments every 2nd tick; B stays 80.
  - Reaches FD0280 after 4 ticks with no wrap.
- **Equal target:** target == `color_o`. Goes straight to HOLD, `color_o` unchanged, `done_o` after exactly `HOLD_PERIODS` ticks.
- **Abort with a coincident step tick:** `color_o` frozen at its pre-tick value, IDLE at the next edge, no `done_o`. A following target ramps from the frozen value.
- **Back-pressure:** hold `target_valid_i` high with a new target during HOLD.
  - Not accepted until IDLE.
  - Accepted in the same cycle `done_o` is high; `busy_o` high again the next cycle.
